// File: rtl/rtc_bus_writer.sv
// rtc_bus_writer: writes a time, date or timer register group to an RTC over a
// multiplexed address/data strobe bus. Each register is an address phase then a
// BCD data phase, each phase SETUP(2) / STROBE(4) / HOLD(2), followed by a 1-cycle
// NEXT gap. Define RTC_WR_XFER_EN to append an address-only transfer command
// (0xF0 time/date, 0xF2 timer) after the third register.
module rtc_bus_writer (
  input  logic       clk,
  input  logic       swreset_n,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic [5:0] val_s,
  input  logic [5:0] val_m,
  input  logic [4:0] val_h,
  input  logic [4:0] val_d,
  input  logic [3:0] val_mo,
  input  logic [6:0] val_a,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       ad,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StNext, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;  // 0 address, 1 data
  logic [1:0] idx_q, idx_d;      // register index; 3 marks the transfer command
  logic       accept;
  logic       xfer_phase;

  logic [1:0] sel_q;
  logic [5:0] s_q, m_q;
  logic [4:0] h_q, d_q;
  logic [3:0] mo_q;
  logic [6:0] a_q;

  logic [7:0] addr_byte;
  logic [7:0] data_byte;
  logic [6:0] raw_val;

  assign accept     = (state_q == StIdle) && start && (sel != 2'd3);
  assign xfer_phase = (idx_q == 2'd3);
  assign rd_n       = 1'b1;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    if (v > 7'd99) return 8'h99;
    return {tens, units};
  endfunction

  // State register and phase/cycle/register counters.
  always_ff @(posedge clk or negedge swreset_n) begin
    if (!swreset_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      phase_q <= 1'b0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  // Capture the request on the accepting edge so later input changes are ignored.
  always_ff @(posedge clk or negedge swreset_n) begin
    if (!swreset_n) begin
      sel_q <= 2'd0;
      s_q   <= 6'd0;
      m_q   <= 6'd0;
      h_q   <= 5'd0;
      d_q   <= 5'd0;
      mo_q  <= 4'd0;
      a_q   <= 7'd0;
    end else if (accept) begin
      sel_q <= sel;
      s_q   <= val_s;
      m_q   <= val_m;
      h_q   <= val_h;
      d_q   <= val_d;
      mo_q  <= val_mo;
      a_q   <= val_a;
    end
  end

  // Next-state: phase timing, address->data sequencing, register advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSetup;
          cnt_d   = 2'd0;
          phase_d = 1'b0;
          idx_d   = 2'd0;
        end
      end
      StSetup: begin
        if (cnt_q == 2'd1) begin
          state_d = StStrobe;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StStrobe: begin
        if (cnt_q == 2'd3) begin
          state_d = StHold;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StHold: begin
        if (cnt_q == 2'd1) begin
          cnt_d = 2'd0;
          if (xfer_phase) begin
            state_d = StDone;
          end else if (!phase_q) begin
            state_d = StSetup;
            phase_d = 1'b1;
          end else begin
            state_d = StNext;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StNext: begin
        phase_d = 1'b0;
        if (idx_q == 2'd2) begin
`ifdef RTC_WR_XFER_EN
          state_d = StSetup;
          idx_d   = 2'd3;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StSetup;
          idx_d   = idx_q + 2'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Address and BCD data for the current register of the captured group.
  always_comb begin
    raw_val   = 7'd0;
    addr_byte = 8'h21;
    if (xfer_phase) begin
      addr_byte = (sel_q == 2'd2) ? 8'hF2 : 8'hF0;
    end else begin
      unique case (sel_q)
        2'd1:    addr_byte = 8'h24 + {6'd0, idx_q};
        2'd2:    addr_byte = 8'h41 + {6'd0, idx_q};
        default: addr_byte = 8'h21 + {6'd0, idx_q};
      endcase
    end
    if (sel_q == 2'd1) begin
      unique case (idx_q)
        2'd0:    raw_val = {2'd0, d_q};
        2'd1:    raw_val = {3'd0, mo_q};
        default: raw_val = a_q;
      endcase
    end else begin
      unique case (idx_q)
        2'd0:    raw_val = {1'b0, s_q};
        2'd1:    raw_val = {1'b0, m_q};
        default: raw_val = {2'd0, h_q};
      endcase
    end
    data_byte = to_bcd(raw_val);
  end

  // Bus outputs decoded from state; reset forces IDLE values through state_q.
  always_comb begin
    cs_n    = 1'b1;
    wr_n    = 1'b1;
    ad      = 1'b0;
    bus_out = 8'h00;
    bus_oe  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StSetup, StStrobe, StHold: begin
        cs_n    = 1'b0;
        bus_oe  = 1'b1;
        wr_n    = (state_q != StStrobe);
        ad      = phase_q;
        bus_out = phase_q ? data_byte : addr_byte;
        busy    = 1'b1;
      end
      StNext:  busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_writer.sv
// Bench for rtc_bus_writer: a queue of expected per-cycle bus states built from
// the transaction rules, checked every cycle, plus literal checks of key cases.
module tb_rtc_bus_writer;

`ifdef RTC_WR_XFER_EN
  localparam int BusyLen = 59;
  localparam bit Xfer    = 1'b1;
`else
  localparam int BusyLen = 51;
  localparam bit Xfer    = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       swreset_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [5:0] val_s = 6'd0, val_m = 6'd0;
  logic [4:0] val_h = 5'd0, val_d = 5'd0;
  logic [3:0] val_mo = 4'd0;
  logic [6:0] val_a = 7'd0;
  logic       cs_n, wr_n, rd_n, ad, bus_oe, busy, done;
  logic [7:0] bus_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       cs_n;
    logic       wr_n;
    logic       oe;
    logic       ad;
    logic [7:0] bus;
    logic       busy;
    logic       done;
    logic       chk_bus;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] obs[$];
  int         busy_run = 0, done_len = 0, done_cnt = 0;
  int         wr_run = 0, wr_min = 99, wr_max = 0;
  logic       wr_prev = 1'b1;

  rtc_bus_writer dut (
    .clk      (clk),
    .swreset_n(swreset_n),
    .start    (start),
    .sel      (sel),
    .val_s    (val_s),
    .val_m    (val_m),
    .val_h    (val_h),
    .val_d    (val_d),
    .val_mo   (val_mo),
    .val_a    (val_a),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .rd_n     (rd_n),
    .ad       (ad),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic c, logic w, logic o, logic a, logic [7:0] b,
                              logic bz, logic dn, logic cb);
    exp_t e;
    e.cs_n = c; e.wr_n = w; e.oe = o; e.ad = a; e.bus = b;
    e.busy = bz; e.done = dn; e.chk_bus = cb;
    return e;
  endfunction

  function automatic logic [7:0] bcd(int v);
    if (v > 99) return 8'h99;
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // One bus phase: 2 setup, 4 strobe, 2 hold cycles.
  task automatic push_phase(logic a, logic [7:0] b);
    for (int i = 0; i < 8; i++)
      exp_q.push_back(mk(1'b0, !(i >= 2 && i < 6), 1'b1, a, b, 1'b1, 1'b0, 1'b1));
  endtask

  task automatic push_txn(int g, int v0, int v1, int v2);
    int addr_tab[3][3];
    int v[3];
    addr_tab = '{'{'h21, 'h22, 'h23}, '{'h24, 'h25, 'h26}, '{'h41, 'h42, 'h43}};
    v = '{v0, v1, v2};
    for (int r = 0; r < 3; r++) begin
      push_phase(1'b0, 8'(addr_tab[g][r]));
      push_phase(1'b1, bcd(v[r]));
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    end
    if (Xfer) push_phase(1'b0, (g == 2) ? 8'hF2 : 8'hF0);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1));
  endtask

  task automatic chk(string name, int got, int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Per-cycle compare at the falling edge, then model acceptance for the next edge.
  task automatic cycle_check();
    exp_t e;
    bit   was_empty;
    bit   bad;
    was_empty = (exp_q.size() == 0);
    if (!swreset_n) begin
      exp_q.delete();
      was_empty = 1'b0;
      e = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end else if (was_empty) begin
      e = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end else begin
      e = exp_q.pop_front();
    end
    bad = (cs_n !== e.cs_n) || (wr_n !== e.wr_n) || (bus_oe !== e.oe) || (rd_n !== 1'b1) ||
          (busy !== e.busy) || (done !== e.done) ||
          (e.chk_bus && ((ad !== e.ad) || (bus_out !== e.bus)));
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t: got cs_n=%b wr_n=%b rd_n=%b oe=%b ad=%b bus=%h busy=%b done=%b, required cs_n=%b wr_n=%b rd_n=1 oe=%b ad=%b bus=%h busy=%b done=%b",
               $time, cs_n, wr_n, rd_n, bus_oe, ad, bus_out, busy, done,
               e.cs_n, e.wr_n, e.oe, e.ad, e.bus, e.busy, e.done);
    end
    if (!wr_n && wr_prev) obs.push_back({ad, bus_out});
    wr_prev = wr_n;
    if (!wr_n) wr_run++;
    else if (wr_run > 0) begin
      if (wr_run < wr_min) wr_min = wr_run;
      if (wr_run > wr_max) wr_max = wr_run;
      wr_run = 0;
    end
    if (done) begin
      done_len = busy_run;
      done_cnt++;
    end
    if (busy) busy_run++;
    else busy_run = 0;
    if (swreset_n && was_empty && start && sel != 2'd3) begin
      if (sel == 2'd1) push_txn(1, int'(val_d), int'(val_mo), int'(val_a));
      else push_txn(int'(sel), int'(val_s), int'(val_m), int'(val_h));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  // Directed transaction with input disturbance and a mid-transaction restart attempt.
  task automatic run_txn(logic [1:0] g, int s, int m, int h, int d, int mo, int a);
    obs.delete();
    wr_min = 99; wr_max = 0; done_cnt = 0; done_len = 0;
    sel = g; val_s = 6'(s); val_m = 6'(m); val_h = 5'(h);
    val_d = 5'(d); val_mo = 4'(mo); val_a = 7'(a);
    start = 1'b1;
    tick();
    start = 1'b0;
    val_s = 6'($urandom); val_m = 6'($urandom); val_h = 5'($urandom);
    val_d = 5'($urandom); val_mo = 4'($urandom); val_a = 7'($urandom);
    sel = 2'(g + 2'd1);
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      start = (i == 10);
      tick();
    end
    start = 1'b0;
    tick();
    tick();
    chk("done_pulse_count", done_cnt, 1);
    chk("busy_cycles", done_len, BusyLen);
    chk("wr_low_min", wr_min, 4);
    chk("wr_low_max", wr_max, 4);
  endtask

  task automatic check_seq(string name, logic [8:0] e[7]);
    int n;
    n = Xfer ? 7 : 6;
    chk({name, "_len"}, obs.size(), n);
    for (int i = 0; i < n && i < obs.size(); i++) chk(name, int'(obs[i]), int'(e[i]));
  endtask

  initial begin
    logic [8:0] e[7];
    int rand_done;

    repeat (3) tick();
    chk("rst_cs_n", cs_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_rd_n", rd_n, 1);
    chk("rst_ad", ad, 0);
    chk("rst_bus_out", bus_out, 0);
    chk("rst_bus_oe", bus_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    swreset_n = 1'b1;

    run_txn(2'd0, 45, 7, 23, 0, 0, 0);
    e = '{9'h021, 9'h145, 9'h022, 9'h107, 9'h023, 9'h123, 9'h0F0};
    check_seq("time_seq", e);

    run_txn(2'd1, 0, 0, 0, 31, 12, 120);
    e = '{9'h024, 9'h131, 9'h025, 9'h112, 9'h026, 9'h199, 9'h0F0};
    check_seq("date_seq", e);

    run_txn(2'd2, 59, 0, 31, 0, 0, 0);
    e = '{9'h041, 9'h159, 9'h042, 9'h100, 9'h043, 9'h131, 9'h0F2};
    check_seq("timer_seq", e);

    sel = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("sel3_busy", busy, 0);
    chk("sel3_cs_n", cs_n, 1);

    // Abort during the second register's address strobe.
    done_cnt = 0;
    sel = 2'd0; val_s = 6'd1; val_m = 6'd2; val_h = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("abort_pre_wr_n", wr_n, 0);
    chk("abort_pre_bus", bus_out, 'h22);
    swreset_n = 1'b0;
    #1;
    chk("abort_wr_n", wr_n, 1);
    chk("abort_cs_n", cs_n, 1);
    chk("abort_bus_oe", bus_oe, 0);
    chk("abort_busy", busy, 0);
    tick();
    tick();
    swreset_n = 1'b1;
    repeat (60) tick();
    chk("abort_no_done", done_cnt, 0);

    // Randomized traffic, including restarts, sel=3 and occasional resets.
    done_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      swreset_n = ($urandom_range(0, 399) != 0);
      sel    = 2'($urandom_range(0, 3));
      start  = ($urandom_range(0, 9) == 0);
      val_s  = 6'($urandom);
      val_m  = 6'($urandom);
      val_h  = 5'($urandom);
      val_d  = 5'($urandom);
      val_mo = 4'($urandom);
      val_a  = 7'($urandom);
      tick();
    end
    swreset_n = 1'b1;
    start = 1'b0;
    repeat (70) tick();
    rand_done = (done_cnt >= 5) ? 1 : 0;
    chk("random_completions", rand_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_writer.md
RTC_BUS_WRITER -- requirements
Module: rtc_bus_writer

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock; one clock domain.
- swreset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle write request.
- sel  in  2  group to write: 0 time, 1 date, 2 timer, 3 invalid.
- val_s, val_m  in  6  seconds and minutes, binary; also timer seconds and minutes.
- val_h  in  5  hours, binary.
- val_d  in  5  day, binary.
- val_mo  in  4  month, binary.
- val_a  in  7  year, binary.
- cs_n, wr_n, rd_n  out  1  RTC bus strobes, active-low.
- ad  out  1  bus phase: 0 address, 1 data.
- bus_out  out  8  address or BCD data byte.
- bus_oe  out  1  bus driver enable.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-002 The block SHALL accept start only when busy=0 and sel≠3; start while busy=1, or with sel=3, SHALL be ignored.
REQ-003 On an accepted start, the block SHALL capture sel and all val_* inputs into internal registers; input changes during a transaction SHALL NOT affect it.
REQ-004 busy SHALL go high on the clock edge that accepts start and SHALL stay high through the last HOLD cycle.
REQ-005 Register sequence per group:
- time: 0x21 seconds, 0x22 minutes, 0x23 hours.
- date: 0x24 day, 0x25 month, 0x26 year.
- timer: 0x41 seconds, 0x42 minutes, 0x43 hours.
REQ-006 Each register write SHALL consist of an address phase (ad=0, bus_out=address) followed by a data phase (ad=1, bus_out=BCD data).
REQ-007 Each phase SHALL use states SETUP (2 cycles), STROBE (4 cycles), HOLD (2 cycles):
- cs_n=0 and bus_oe=1 in all three states.
- wr_n=0 only in STROBE.
- rd_n=1 always.
REQ-008 The FSM states SHALL be IDLE, SETUP, STROBE, HOLD, NEXT and DONE.
- IDLE to SETUP on an accepted start.
- HOLD to SETUP for the data phase.
- HOLD to NEXT after the data phase.
- NEXT advances the register index, or goes to DONE after the last register.
- DONE to IDLE.
- NEXT SHALL last 1 cycle with cs_n=1 and bus_oe=0.
REQ-009 BCD encoding:
- data = {tens[3:0], units[3:0]}, with tens = v/10 and units = v%10.
- Values above 99 SHALL saturate to 0x99.
- Narrower fields SHALL be zero-extended before encoding.
REQ-010 done SHALL pulse high for exactly 1 cycle in state DONE; busy SHALL be 0 in that same cycle.
REQ-011 Latency: a 3-register transaction SHALL take 3×(16+1) = 51 busy cycles from the accept edge, with done in the following cycle.
REQ-012 In IDLE, outputs SHALL be: cs_n=1, wr_n=1, rd_n=1, ad=0, bus_out=0x00, bus_oe=0, busy=0, done=0.

Reset
REQ-013 swreset_n=0 SHALL immediately force the FSM to IDLE and set all outputs to the IDLE values of REQ-012, asynchronously and independent of clk.
REQ-014 Reset mid-transaction SHALL abort the transaction without a done pulse; captured registers SHALL clear to 0.
REQ-015 Reset release SHALL take effect on the next clk edge; the first start is accepted no earlier than that edge.

Configuration
REQ-016 Macro RTC_WR_XFER_EN SHALL control a transfer command after the third register:
- Defined: after the third register's NEXT, the block SHALL issue one extra address-only phase (SETUP/STROBE/HOLD, ad=0, no data phase), then go to DONE.
- Transfer command address: 0xF0 for time and date, 0xF2 for timer.
- Busy length with the macro defined: 51+8 = 59 cycles.
- Undefined: there SHALL be no transfer phase, and timing SHALL be exactly as in REQ-011.

Verification
REQ-017 Reset values: hold swreset_n=0, then release -> all outputs equal REQ-012 values and busy=0.
REQ-018 Time write: sel=0, val_s=45, val_m=7, val_h=23, start -> bus sequence 0x21/0x45, 0x22/0x07, 0x23/0x23; wr_n low for exactly 4 cycles per phase; done 1 cycle after 51 busy cycles.
REQ-019 Date saturation: sel=1, val_d=31, val_mo=12, val_a=120, start -> data bytes 0x31, 0x12, 0x99.
REQ-020 Ignored starts and input capture:
- start pulsed again mid-transaction -> no restart; busy length unchanged.
- val_* changed after the accept edge -> bus data unchanged.
- sel=3 start -> busy stays 0.
REQ-021 Abort: drive swreset_n low during the STROBE of the second register -> wr_n=1, cs_n=1, bus_oe=0 within the same cycle; no done pulse.
REQ-022 Transfer command: with RTC_WR_XFER_EN defined, sel=2 start -> final address phase 0xF2 with ad=0; done after 59 busy cycles.
